pipelined_cla_addsub: RTL

//  Parametrised, pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.

---
 rtl/pipelined_cla_addsub_if.sv | 32 +++
 rtl/pipelined_cla_addsub.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result stream bundle for the pipelined CLA adder/subtractor.
// slave = the arithmetic core, master = whoever feeds operands and sinks results.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_cin;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_x, in_y, in_cin, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_x, in_y, in_cin, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined segmented CLA adder/subtractor, one SEG_W-bit segment per stage, carry registered between stages.
// Latency: WIDTH/SEG_W cycles, 1 beat/cycle throughput.
// Backpressure: a single advance = !out_valid | out_ready freezes every stage; in_ready = advance.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8,
    parameter int TAG_W = 4
) (
    input logic                   clk,
    input logic                   reset,
    pipelined_cla_addsub_if.slave bus
);
    localparam int NSEG = WIDTH / SEG_W;
    localparam int NR   = (NSEG > 1) ? NSEG - 1 : 1;
    localparam int NG   = SEG_W / 4;

    // Returns carries c[0..SEG_W] of one segment; c[0] is the segment carry-in.
    function automatic logic [SEG_W:0] cla_carries(input logic [SEG_W-1:0] a,
                                                   input logic [SEG_W-1:0] b,
                                                   input logic             cin);
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] p;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
        logic [NG:0]      gc;
        logic [SEG_W:0]   c;
        g = a & b;
        p = a ^ b;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = cin;
        for (int j = 0; j < NG; j++)
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        c = '0;
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        c[SEG_W] = gc[NG];
        return c;
    endfunction

    logic advance;

    // Stage inputs: stage 0 from the port, stage k from the register behind stage k-1.
    logic             st_v   [NSEG];
    logic [WIDTH-1:0] st_x   [NSEG];
    logic [WIDTH-1:0] st_y   [NSEG];
    logic             st_c   [NSEG];
    logic [TAG_W-1:0] st_tag [NSEG];

    logic [SEG_W:0]   car [NSEG];
    logic [SEG_W-1:0] seg [NSEG];
    logic [WIDTH-1:0] nx  [NSEG];

    logic             r_v   [NR];
    logic [WIDTH-1:0] r_x   [NR];
    logic [WIDTH-1:0] r_y   [NR];
    logic             r_c   [NR];
    logic [TAG_W-1:0] r_tag [NR];

    logic             o_v;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;
    logic             o_zero;
    logic [TAG_W-1:0] o_tag;

    assign advance      = !o_v || bus.out_ready;
    assign bus.in_ready = advance;

    always_comb begin
        st_v[0]   = bus.in_valid;
        st_x[0]   = bus.in_x;
        st_y[0]   = bus.in_sub ? ~bus.in_y : bus.in_y;
        st_c[0]   = bus.in_sub | bus.in_cin;
        st_tag[0] = bus.in_tag;
        for (int k = 1; k < NSEG; k++) begin
            st_v[k]   = r_v[k-1];
            st_x[k]   = r_x[k-1];
            st_y[k]   = r_y[k-1];
            st_c[k]   = r_c[k-1];
            st_tag[k] = r_tag[k-1];
        end
    end

    // Each stage works on the low segment and rotates its finished slice in at the top,
    // so after NSEG stages the X lane holds the whole sum in natural bit order.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            car[k] = cla_carries(st_x[k][SEG_W-1:0], st_y[k][SEG_W-1:0], st_c[k]);
            seg[k] = st_x[k][SEG_W-1:0] ^ st_y[k][SEG_W-1:0] ^ car[k][SEG_W-1:0];
            nx[k]  = (st_x[k] >> SEG_W) | (WIDTH'(seg[k]) << (WIDTH - SEG_W));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NR; k++) begin
                r_v[k]   <= 1'b0;
                r_x[k]   <= '0;
                r_y[k]   <= '0;
                r_c[k]   <= 1'b0;
                r_tag[k] <= '0;
            end
            o_v    <= 1'b0;
            o_sum  <= '0;
            o_cout <= 1'b0;
            o_ovf  <= 1'b0;
            o_zero <= 1'b0;
            o_tag  <= '0;
        end else if (advance) begin
            for (int k = 0; k < NSEG - 1; k++) begin
                r_v[k]   <= st_v[k];
                r_x[k]   <= nx[k];
                r_y[k]   <= st_y[k] >> SEG_W;
                r_c[k]   <= car[k][SEG_W];
                r_tag[k] <= st_tag[k];
            end
            o_v    <= st_v[NSEG-1];
            o_sum  <= nx[NSEG-1];
            o_cout <= car[NSEG-1][SEG_W];
            o_ovf  <= car[NSEG-1][SEG_W] ^ car[NSEG-1][SEG_W-1];
            o_zero <= (nx[NSEG-1] == '0);
            o_tag  <= st_tag[NSEG-1];
        end
    end

    assign bus.out_valid = o_v;
    assign bus.out_sum   = o_sum;
    assign bus.out_cout  = o_cout;
    assign bus.out_ovf   = o_ovf;
    assign bus.out_zero  = o_zero;
    assign bus.out_tag   = o_tag;
endmodule
